// File: rtl/health_controller.sv
// Round-level health/damage controller: round-robin hit arbitration, saturating damage,
// per-victim invulnerability windows and the IDLE/FIGHT/KO round sequence.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | healths held full, requests acked and dropped, wait round_start
// FIGHT | one hit serviced per cycle, round-robin between players
// KO    | requests acked and dropped, hold KO_HOLD_TICKS ticks then IDLE
module health_controller #(
    parameter int FULL_HEALTH   = 200,
    parameter int INVULN_TICKS  = 25,
    parameter int KO_HOLD_TICKS = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       round_start,
    input  logic       p1_hit_req,
    input  logic [7:0] p1_dmg,
    input  logic       p2_hit_req,
    input  logic [7:0] p2_dmg,
    output logic       p1_hit_ack,
    output logic       p2_hit_ack,
    output logic [8:0] p1_health,
    output logic [8:0] p2_health,
    output logic [1:0] state,
    output logic [1:0] winner
);
    localparam int IW = $clog2(INVULN_TICKS + 1);
    localparam int KW = $clog2(KO_HOLD_TICKS + 1);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_FIGHT = 2'b01;
    localparam logic [1:0] ST_KO    = 2'b10;

    localparam logic [8:0]    HEALTH_FULL = 9'(FULL_HEALTH);
    localparam logic [IW-1:0] INV_LOAD    = IW'(INVULN_TICKS);
    localparam logic [KW-1:0] KO_LOAD     = KW'(KO_HOLD_TICKS);

    logic [IW-1:0] p1_inv_cnt;
    logic [IW-1:0] p2_inv_cnt;
    logic [KW-1:0] ko_cnt;
    logic          ptr_p2;

    logic          p1_elig;
    logic          p2_elig;
    logic          serve_p1;
    logic          serve_p2;
    logic          hit_on_p1;
    logic          hit_on_p2;
    logic [8:0]    p1_next;
    logic [8:0]    p2_next;
    logic          ack1_d;
    logic          ack2_d;

    // A requester whose ack is high this cycle may still be holding req; ignore it.
    assign p1_elig  = p1_hit_req & ~p1_hit_ack;
    assign p2_elig  = p2_hit_req & ~p2_hit_ack;
    assign serve_p1 = (state == ST_FIGHT) & p1_elig & (~p2_elig | ~ptr_p2);
    assign serve_p2 = (state == ST_FIGHT) & p2_elig & (~p1_elig |  ptr_p2);

    // P1's hit lands on P2 and vice versa.
    assign hit_on_p2 = serve_p1 & (p2_inv_cnt == '0) & (p1_dmg != 8'd0);
    assign hit_on_p1 = serve_p2 & (p1_inv_cnt == '0) & (p2_dmg != 8'd0);
    assign p2_next   = ({1'b0, p1_dmg} >= p2_health) ? 9'd0 : p2_health - {1'b0, p1_dmg};
    assign p1_next   = ({1'b0, p2_dmg} >= p1_health) ? 9'd0 : p1_health - {1'b0, p2_dmg};

    always_comb begin
        ack1_d = 1'b0;
        ack2_d = 1'b0;
        if (state == ST_FIGHT) begin
            ack1_d = serve_p1;
            ack2_d = serve_p2;
        end else begin
            ack1_d = p1_elig;
            ack2_d = p2_elig;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            winner     <= 2'b00;
            p1_health  <= HEALTH_FULL;
            p2_health  <= HEALTH_FULL;
            p1_hit_ack <= 1'b0;
            p2_hit_ack <= 1'b0;
            p1_inv_cnt <= '0;
            p2_inv_cnt <= '0;
            ko_cnt     <= '0;
            ptr_p2     <= 1'b0;
        end else begin
            p1_hit_ack <= ack1_d;
            p2_hit_ack <= ack2_d;
            if (tick && p1_inv_cnt != '0) p1_inv_cnt <= p1_inv_cnt - IW'(1);
            if (tick && p2_inv_cnt != '0) p2_inv_cnt <= p2_inv_cnt - IW'(1);

            case (state)
                ST_IDLE: begin
                    p1_health <= HEALTH_FULL;
                    p2_health <= HEALTH_FULL;
                    if (round_start) state <= ST_FIGHT;
                end
                ST_FIGHT: begin
                    if (serve_p1) ptr_p2 <= 1'b1;
                    if (serve_p2) ptr_p2 <= 1'b0;
                    if (hit_on_p2) begin
                        p2_health  <= p2_next;
                        p2_inv_cnt <= INV_LOAD;
                        if (p2_next == 9'd0) begin
                            state  <= ST_KO;
                            winner <= 2'b01;
                            ko_cnt <= KO_LOAD;
                        end
                    end
                    if (hit_on_p1) begin
                        p1_health  <= p1_next;
                        p1_inv_cnt <= INV_LOAD;
                        if (p1_next == 9'd0) begin
                            state  <= ST_KO;
                            winner <= 2'b10;
                            ko_cnt <= KO_LOAD;
                        end
                    end
                end
                ST_KO: begin
                    if (tick && ko_cnt != '0) ko_cnt <= ko_cnt - KW'(1);
                    if (tick && ko_cnt == KW'(1)) begin
                        state      <= ST_IDLE;
                        winner     <= 2'b00;
                        p1_health  <= HEALTH_FULL;
                        p2_health  <= HEALTH_FULL;
                        p1_inv_cnt <= '0;
                        p2_inv_cnt <= '0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_health_controller.sv
// Directed bench for health_controller: expected output snapshots are queued with each
// stimulus step and compared against the DUT one edge later.
module tb_health_controller;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       round_start = 1'b0;
    logic       p1_hit_req = 1'b0;
    logic [7:0] p1_dmg = 8'd0;
    logic       p2_hit_req = 1'b0;
    logic [7:0] p2_dmg = 8'd0;
    logic       p1_hit_ack;
    logic       p2_hit_ack;
    logic [8:0] p1_health;
    logic [8:0] p2_health;
    logic [1:0] state;
    logic [1:0] winner;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic       a1;
        logic       a2;
        logic [8:0] h1;
        logic [8:0] h2;
        logic [1:0] st;
        logic [1:0] w;
    } exp_t;

    exp_t sb[$];

    health_controller dut (
        .clk(clk), .reset(reset), .tick(tick), .round_start(round_start),
        .p1_hit_req(p1_hit_req), .p1_dmg(p1_dmg),
        .p2_hit_req(p2_hit_req), .p2_dmg(p2_dmg),
        .p1_hit_ack(p1_hit_ack), .p2_hit_ack(p2_hit_ack),
        .p1_health(p1_health), .p2_health(p2_health),
        .state(state), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input string field, input logic [8:0] obs, input logic [8:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s observed %0d expected %0d", tag, field, obs, exp);
        end
    endtask

    // Queue the expected outputs for the coming edge, clock it, then pop and compare.
    task automatic step(input string tag, input logic a1, input logic a2,
                        input logic [8:0] h1, input logic [8:0] h2,
                        input logic [1:0] st, input logic [1:0] w);
        exp_t e;
        e.tag = tag; e.a1 = a1; e.a2 = a2; e.h1 = h1; e.h2 = h2; e.st = st; e.w = w;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(e.tag, "p1_ack",    {8'd0, p1_hit_ack}, {8'd0, e.a1});
        chk(e.tag, "p2_ack",    {8'd0, p2_hit_ack}, {8'd0, e.a2});
        chk(e.tag, "p1_health", p1_health, e.h1);
        chk(e.tag, "p2_health", p2_health, e.h2);
        chk(e.tag, "state",     {7'd0, state},  {7'd0, e.st});
        chk(e.tag, "winner",    {7'd0, winner}, {7'd0, e.w});
    endtask

    task automatic set_req(input logic r1, input logic [7:0] d1, input logic r2, input logic [7:0] d2);
        p1_hit_req = r1; p1_dmg = d1;
        p2_hit_req = r2; p2_dmg = d2;
    endtask

    initial begin
        // basic hit and invulnerability window
        step("reset", 0, 0, 200, 200, 2'b00, 2'b00);
        reset = 1'b0;
        round_start = 1'b1;
        step("start", 0, 0, 200, 200, 2'b01, 2'b00);
        round_start = 1'b0;
        set_req(1, 30, 0, 0);
        step("hit1", 1, 0, 200, 170, 2'b01, 2'b00);
        set_req(0, 30, 0, 0);
        step("hit1_drop", 0, 0, 200, 170, 2'b01, 2'b00);
        set_req(1, 30, 0, 0);
        step("hit_invuln", 1, 0, 200, 170, 2'b01, 2'b00);
        set_req(0, 30, 0, 0);
        tick = 1'b1;
        for (int i = 0; i < 24; i++) step("inv_wait", 0, 0, 200, 170, 2'b01, 2'b00);
        tick = 1'b0;
        set_req(1, 30, 0, 0);
        step("hit_inv_last", 1, 0, 200, 170, 2'b01, 2'b00);
        set_req(0, 30, 0, 0);
        tick = 1'b1;
        step("inv_tick25", 0, 0, 200, 170, 2'b01, 2'b00);
        tick = 1'b0;
        set_req(1, 30, 0, 0);
        step("hit_after_inv", 1, 0, 200, 140, 2'b01, 2'b00);
        set_req(0, 0, 0, 0);
        step("drop2", 0, 0, 200, 140, 2'b01, 2'b00);

        // round-robin arbitration
        reset = 1'b1;
        step("reset2", 0, 0, 200, 200, 2'b00, 2'b00);
        reset = 1'b0;
        round_start = 1'b1;
        step("start2", 0, 0, 200, 200, 2'b01, 2'b00);
        round_start = 1'b0;
        set_req(1, 10, 1, 20);
        step("arb_p1", 1, 0, 200, 190, 2'b01, 2'b00);
        set_req(0, 10, 1, 20);
        step("arb_p2", 0, 1, 180, 190, 2'b01, 2'b00);
        set_req(0, 0, 0, 0);
        step("arb_idle", 0, 0, 180, 190, 2'b01, 2'b00);
        set_req(1, 10, 1, 20);
        step("arb2_p1", 1, 0, 180, 190, 2'b01, 2'b00);
        set_req(0, 10, 1, 20);
        step("arb2_p2", 0, 1, 180, 190, 2'b01, 2'b00);
        set_req(0, 0, 0, 0);
        step("arb2_idle", 0, 0, 180, 190, 2'b01, 2'b00);

        // zero damage, held request, saturation, KO and hold
        reset = 1'b1;
        step("reset3", 0, 0, 200, 200, 2'b00, 2'b00);
        reset = 1'b0;
        round_start = 1'b1;
        step("start3", 0, 0, 200, 200, 2'b01, 2'b00);
        round_start = 1'b0;
        set_req(1, 0, 0, 0);
        step("dmg0_a", 1, 0, 200, 200, 2'b01, 2'b00);
        step("dmg0_held", 0, 0, 200, 200, 2'b01, 2'b00);
        step("dmg0_new", 1, 0, 200, 200, 2'b01, 2'b00);
        set_req(0, 0, 0, 0);
        step("dmg0_drop", 0, 0, 200, 200, 2'b01, 2'b00);
        set_req(1, 5, 0, 0);
        step("dmg5", 1, 0, 200, 195, 2'b01, 2'b00);
        set_req(0, 0, 0, 0);
        tick = 1'b1;
        for (int i = 0; i < 25; i++) step("wait_a", 0, 0, 200, 195, 2'b01, 2'b00);
        tick = 1'b0;
        set_req(1, 180, 0, 0);
        step("to15", 1, 0, 200, 15, 2'b01, 2'b00);
        set_req(0, 0, 0, 0);
        tick = 1'b1;
        for (int i = 0; i < 25; i++) step("wait_b", 0, 0, 200, 15, 2'b01, 2'b00);
        tick = 1'b0;
        set_req(1, 40, 0, 0);
        step("ko_hit", 1, 0, 200, 0, 2'b10, 2'b01);
        set_req(0, 0, 0, 0);
        step("ko_drop", 0, 0, 200, 0, 2'b10, 2'b01);
        set_req(1, 50, 1, 50);
        round_start = 1'b1;
        step("ko_discard", 1, 1, 200, 0, 2'b10, 2'b01);
        set_req(0, 0, 0, 0);
        round_start = 1'b0;
        tick = 1'b1;
        for (int i = 0; i < 99; i++) step("ko_hold", 0, 0, 200, 0, 2'b10, 2'b01);
        step("ko_exit", 0, 0, 200, 200, 2'b00, 2'b00);
        tick = 1'b0;

        // reset during KO with a handshake in flight
        round_start = 1'b1;
        step("start4", 0, 0, 200, 200, 2'b01, 2'b00);
        round_start = 1'b0;
        set_req(1, 255, 0, 0);
        step("sat_ko", 1, 0, 200, 0, 2'b10, 2'b01);
        set_req(1, 255, 1, 9);
        reset = 1'b1;
        step("reset_mid", 0, 0, 200, 200, 2'b00, 2'b00);
        reset = 1'b0;
        step("idle_discard", 1, 1, 200, 200, 2'b00, 2'b00);
        set_req(0, 0, 0, 0);
        step("final", 0, 0, 200, 200, 2'b00, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
